sm_input_filter: RTL and testbench



---
 rtl/sm_input_filter_pkg.sv | 32 +++
 rtl/sm_input_filter_if.sv | 35 +++
 rtl/sm_input_filter_channel.sv | 78 +++++++
 rtl/sm_input_filter.sv | 47 ++++
 tb/tb_sm_input_filter.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sm_input_filter_pkg.sv
// Shared definitions for the multi-channel input conditioner: default hold
// time, legal synchroniser depth range and the per-channel edge classification.
package sm_input_filter_pkg;

    // Default stability window: about 1 ms at a 50 MHz clock.
    localparam logic [15:0] SM_FILTER_HOLD = 16'd50000;

    // Synchroniser depth limits. Two flops are the minimum for metastability
    // settling; more than four only adds latency.
    localparam int SM_SYNC_STAGES_MIN = 2;
    localparam int SM_SYNC_STAGES_MAX = 4;

    // Kind of transition accepted on a channel in a given cycle.
    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10
    } edgeKind_t;

    // Maps an accepted level change onto its strobe kind.
    function automatic edgeKind_t classifyEdge(input logic oldLevel, input logic newLevel);
        edgeKind_t kind;
        kind = EDGE_NONE;
        if (!oldLevel && newLevel) begin
            kind = EDGE_RISE;
        end else if (oldLevel && !newLevel) begin
            kind = EDGE_FALL;
        end
        return kind;
    endfunction

endpackage

// File: rtl/sm_input_filter_if.sv
// Signal bundle between the board-side inputs and the filtered outputs.
// There is no valid/ready handshake: d and holdCycles are free-running levels
// sampled on every clk edge, q is a level, and rise/fall/changed are one-cycle
// strobes that the consumer must sample on the cycle they are high.
interface sm_input_filter_if #(
    parameter int WIDTH     = 5,
    parameter int CNT_WIDTH = 16
);
    logic [WIDTH-1:0]     d;
    logic [CNT_WIDTH-1:0] holdCycles;
    logic [WIDTH-1:0]     q;
    logic [WIDTH-1:0]     rise;
    logic [WIDTH-1:0]     fall;
    logic                 changed;

    // Side that drives the raw inputs and consumes the filtered result.
    modport master (
        output d,
        output holdCycles,
        input  q,
        input  rise,
        input  fall,
        input  changed
    );

    // The filter itself.
    modport slave (
        input  d,
        input  holdCycles,
        output q,
        output rise,
        output fall,
        output changed
    );
endinterface

// File: rtl/sm_input_filter_channel.sv
// One conditioner channel: shift-register synchroniser, stability counter,
// comparator and registered rise/fall strobes. The filtered level only moves
// after the synchronised input has disagreed with it for holdCycles+1 cycles.
module sm_filter_channel
    import sm_input_filter_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16,
    parameter bit RESET_VALUE = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 d,
    input  logic [CNT_WIDTH-1:0] holdCycles,
    output logic                 q,
    output logic                 rise,
    output logic                 fall
);

    if (SYNC_STAGES < SM_SYNC_STAGES_MIN || SYNC_STAGES > SM_SYNC_STAGES_MAX) begin : gBadStages
        $error("sm_filter_channel: SYNC_STAGES out of range");
    end

    logic [SYNC_STAGES-1:0] syncReg;
    logic                   s;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [CNT_WIDTH-1:0]   cntNext;
    logic                   qNext;
    edgeKind_t              edgeNext;

    // The last synchroniser flop is the only view of d the filter ever uses.
    assign s = syncReg[SYNC_STAGES-1];

    // Synchroniser shift register. It resets to the same value as q so that
    // releasing reset can never produce a strobe, whatever level d sits at.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncReg <= {SYNC_STAGES{RESET_VALUE}};
        end else if (SYNC_STAGES > 1) begin
            syncReg <= {syncReg[SYNC_STAGES-2:0], d};
        end else begin
            syncReg <= {SYNC_STAGES{d}};
        end
    end

    // Stability decision: count mismatch cycles, accept once the count reaches
    // holdCycles. Using >= means a mid-count reduction of holdCycles takes
    // effect on the very next mismatch cycle, and the counter can never wrap.
    always_comb begin
        qNext    = q;
        cntNext  = '0;
        edgeNext = EDGE_NONE;
        if (s != q) begin
            if (cnt >= holdCycles) begin
                qNext    = s;
                edgeNext = classifyEdge(q, s);
            end else begin
                cntNext = cnt + 1'b1;
            end
        end
    end

    // Filtered level, counter and strobes; all outputs leave straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= RESET_VALUE;
            cnt  <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            q    <= qNext;
            cnt  <= cntNext;
            rise <= (edgeNext == EDGE_RISE);
            fall <= (edgeNext == EDGE_FALL);
        end
    end

endmodule

// File: rtl/sm_input_filter.sv
// Multi-channel input conditioner for board switches and buttons. Each channel
// is fully independent; the top level only merges the per-channel strobes into
// a single changed flag.
module sm_input_filter
    import sm_input_filter_pkg::*;
#(
    parameter int WIDTH       = 5,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16,
    parameter bit RESET_VALUE = 1'b0
) (
    input logic              clk,
    input logic              rst_n,
    sm_input_filter_if.slave bus
);

    logic [WIDTH-1:0] qVec;
    logic [WIDTH-1:0] riseVec;
    logic [WIDTH-1:0] fallVec;

    for (genvar i = 0; i < WIDTH; i++) begin : gChan
        sm_filter_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_WIDTH   (CNT_WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) uChan (
            .clk        (clk),
            .rst_n      (rst_n),
            .d          (bus.d[i]),
            .holdCycles (bus.holdCycles),
            .q          (qVec[i]),
            .rise       (riseVec[i]),
            .fall       (fallVec[i])
        );
    end

    // Strobes are already registered per channel, so changed is a pure OR of
    // flop outputs and coincides with them; simultaneous channel changes merge
    // into one pulse.
    always_comb begin
        bus.q       = qVec;
        bus.rise    = riseVec;
        bus.fall    = fallVec;
        bus.changed = |{riseVec, fallVec};
    end

endmodule

// File: tb/tb_sm_input_filter.sv
// Bench for sm_input_filter: directed scenarios plus a randomised run, all
// compared against a reference model built from the filtering rules.
`timescale 1ns/1ps
module tb_sm_input_filter;

    localparam int W  = 5;
    localparam int SS = 2;
    localparam int CW = 16;
    localparam bit RV = 1'b0;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sm_input_filter_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus ();

    sm_input_filter #(
        .WIDTH       (W),
        .SYNC_STAGES (SS),
        .CNT_WIDTH   (CW),
        .RESET_VALUE (RV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    // hist holds the raw d samples of the last SS edges, newest first: the
    // oldest entry is what the filter currently sees after synchronisation.
    logic [W-1:0] hist[$];
    logic [W-1:0] m_q;
    logic [W-1:0] m_rise;
    logic [W-1:0] m_fall;
    int           m_run[W];

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < SS; k++) hist.push_back({W{RV}});
        m_q    = {W{RV}};
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
    endtask

    // One clock edge: a channel flips once it has already disagreed for at
    // least holdCycles previous cycles.
    task automatic model_edge();
        logic [W-1:0] s_seen;
        s_seen = hist[SS-1];
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < W; i++) begin
            if (s_seen[i] != m_q[i]) begin
                if (m_run[i] >= int'(bus.holdCycles)) begin
                    m_q[i] = s_seen[i];
                    if (s_seen[i]) m_rise[i] = 1'b1;
                    else           m_fall[i] = 1'b1;
                    m_run[i] = 0;
                end else begin
                    m_run[i] = m_run[i] + 1;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        hist.push_front(bus.d);
        void'(hist.pop_back());
    endtask

    function automatic logic [3*W:0] model_vec();
        return {m_q, m_rise, m_fall, |{m_rise, m_fall}};
    endfunction

    function automatic logic [3*W:0] dut_vec();
        return {bus.q, bus.rise, bus.fall, bus.changed};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic start_clean(input int hold);
        rst_n          = 1'b0;
        bus.d          = '0;
        bus.holdCycles = CW'(hold);
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int hit;
        int strobes;
        rst_n          = 1'b0;
        bus.d          = 5'h1F;
        bus.holdCycles = 16'd3;
        model_reset();
        #1;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            checks++;
            if (dut_vec() !== '0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=0", n, dut_vec());
            end
        end
        rst_n   = 1'b1;
        hit     = -1;
        strobes = 0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                $display("FAIL reset_model cyc=%0d got=%h exp=%h", n, dut_vec(), model_vec());
            end
            if (bus.changed === 1'b1) strobes++;
            if (hit < 0 && bus.q === 5'h1F) begin
                hit = n;
                checks++;
                if (bus.rise !== 5'h1F || bus.changed !== 1'b1) begin
                    failures++;
                    $display("FAIL reset_rise_strobe rise=%h changed=%b exp rise=1f changed=1", bus.rise, bus.changed);
                end
            end
        end
        checks++;
        if (hit != SS + 3 + 1) begin
            failures++;
            $display("FAIL reset_latency got=%0d exp=%0d", hit, SS + 3 + 1);
        end
        checks++;
        if (strobes != 1) begin
            failures++;
            $display("FAIL reset_strobe_count got=%0d exp=1", strobes);
        end
    endtask

    task automatic test_glitch();
        int hit;
        start_clean(4);
        for (int n = 1; n <= 18; n++) begin
            bus.d[0] = (n >= 3 && n <= 6);
            tick();
            checks++;
            if (dut_vec() !== model_vec() || bus.q[0] !== 1'b0 || bus.rise[0] !== 1'b0 || bus.changed !== 1'b0) begin
                failures++;
                $display("FAIL glitch_reject cyc=%0d got=%h exp=%h", n, dut_vec(), model_vec());
            end
        end
        // A fresh full-length pulse must need the whole window again, which
        // only holds if the glitch left no residue in the counter.
        bus.d[0] = 1'b1;
        hit = -1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                $display("FAIL glitch_model cyc=%0d got=%h exp=%h", n, dut_vec(), model_vec());
            end
            if (hit < 0 && bus.q[0] === 1'b1) hit = n;
        end
        checks++;
        if (hit != 7) begin
            failures++;
            $display("FAIL glitch_counter_cleared got=%0d exp=7", hit);
        end
    endtask

    task automatic test_threshold();
        int rise_at, rise_cnt, fall_at, fall_cnt;
        start_clean(4);
        rise_at = -1; rise_cnt = 0; fall_at = -1; fall_cnt = 0;
        for (int n = 1; n <= 20; n++) begin
            bus.d[0] = (n <= 5);
            tick();
            checks++;
            if (dut_vec() !== model_vec() || bus.q[0] !== (n >= 7 && n < 12)) begin
                failures++;
                $display("FAIL threshold_level cyc=%0d got=%h exp=%h", n, dut_vec(), model_vec());
            end
            if (bus.rise[0] === 1'b1) begin rise_at = n; rise_cnt++; end
            if (bus.fall[0] === 1'b1) begin fall_at = n; fall_cnt++; end
        end
        checks++;
        if (rise_at != 7 || rise_cnt != 1) begin
            failures++;
            $display("FAIL threshold_rise at=%0d count=%0d exp at=7 count=1", rise_at, rise_cnt);
        end
        checks++;
        if (fall_at != 12 || fall_cnt != 1) begin
            failures++;
            $display("FAIL threshold_fall at=%0d count=%0d exp at=12 count=1", fall_at, fall_cnt);
        end
    endtask

    task automatic test_bypass();
        logic [W-1:0] exp_q[$];
        logic [W-1:0] exp_level;
        logic [W-1:0] prev_level;
        logic [W-1:0] exp_rise;
        logic [W-1:0] exp_fall;
        start_clean(0);
        prev_level = {W{RV}};
        for (int n = 1; n <= 20; n++) begin
            bus.d[2] = (((n - 1) / 2) % 2 == 0);
            exp_q.push_back(bus.d);
            tick();
            exp_level = prev_level;
            if (exp_q.size() > 2) exp_level = exp_q.pop_front();
            exp_rise = exp_level & ~prev_level;
            exp_fall = ~exp_level & prev_level;
            checks++;
            if (bus.q !== exp_level || bus.rise !== exp_rise || bus.fall !== exp_fall || dut_vec() !== model_vec()) begin
                failures++;
                $display("FAIL bypass cyc=%0d q=%h rise=%h fall=%h exp q=%h rise=%h fall=%h",
                         n, bus.q, bus.rise, bus.fall, exp_level, exp_rise, exp_fall);
            end
            prev_level = exp_level;
        end
    endtask

    task automatic test_simultaneous();
        int changed_at, changed_cnt;
        start_clean(10);
        bus.d = 5'b01010;
        changed_at = -1; changed_cnt = 0;
        for (int n = 1; n <= 14; n++) begin
            if (n == 6) bus.holdCycles = 16'd2;
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                $display("FAIL simul_model cyc=%0d got=%h exp=%h", n, dut_vec(), model_vec());
            end
            if (bus.changed === 1'b1) begin
                changed_at = n;
                changed_cnt++;
                checks++;
                if (bus.q !== 5'b01010 || bus.rise !== 5'b01010) begin
                    failures++;
                    $display("FAIL simul_both q=%h rise=%h exp q=0a rise=0a", bus.q, bus.rise);
                end
            end
        end
        checks++;
        if (changed_at != 6 || changed_cnt != 1) begin
            failures++;
            $display("FAIL simul_changed at=%0d count=%0d exp at=6 count=1", changed_at, changed_cnt);
        end
    endtask

    task automatic test_midreset();
        int hit;
        start_clean(8);
        bus.d = 5'b00001;
        for (int n = 1; n <= 14; n++) begin
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                $display("FAIL midreset_pre cyc=%0d got=%h exp=%h", n, dut_vec(), model_vec());
            end
        end
        bus.d = 5'b10001;
        for (int n = 1; n <= 5; n++) tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== '0) begin
            failures++;
            $display("FAIL midreset_immediate got=%h exp=0", dut_vec());
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        hit = -1;
        for (int n = 1; n <= 16; n++) begin
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                $display("FAIL midreset_model cyc=%0d got=%h exp=%h", n, dut_vec(), model_vec());
            end
            if (hit < 0 && bus.q !== 5'b00000) begin
                hit = n;
                checks++;
                if (bus.q !== 5'b10001 || bus.rise !== 5'b10001) begin
                    failures++;
                    $display("FAIL midreset_value q=%h rise=%h exp q=11 rise=11", bus.q, bus.rise);
                end
            end
        end
        checks++;
        if (hit != SS + 9) begin
            failures++;
            $display("FAIL midreset_latency got=%0d exp=%0d", hit, SS + 9);
        end
    endtask

    task automatic test_random();
        start_clean($urandom_range(0, 5));
        for (int n = 1; n <= 400; n++) begin
            if ($urandom_range(0, 5) == 0) bus.d[$urandom_range(0, W - 1)] = ~bus.d[$urandom_range(0, W - 1)];
            if ($urandom_range(0, 19) == 0) bus.d = W'($urandom);
            if (n % 60 == 0) bus.holdCycles = CW'($urandom_range(0, 6));
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                $display("FAIL random cyc=%0d hold=%0d got=%h exp=%h", n, bus.holdCycles, dut_vec(), model_vec());
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.d          = '0;
        bus.holdCycles = '0;
        test_reset();
        test_glitch();
        test_threshold();
        test_bypass();
        test_simultaneous();
        test_midreset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
